accum_bcd_display: RTL and testbench
====================================

Name: accum_bcd_display

Overview:
- Downstream display stage for the switch-driven accumulator. It consumes the accumulator's binary sum and shows it in decimal on the board's seven-segment displays.
- Conversion is a sequential shift-and-add-3 (double-dabble) FSM, one bit per clock. It starts automatically whenever the input value differs from the last converted value.
- Display registers update atomically on conversion completion, so a partial result never reaches the HEX outputs.

Parameters:
- WIDTH, 10, width of the binary input value.
- DIGITS, 4, number of decimal digits and HEX displays. Must satisfy 10^DIGITS > 2^WIDTH - 1; the instantiation-time check is a simulation $error.

Ports:
- CLOCK  input  1  system clock, rising edge.
- RESETn  input  1  asynchronous, active-low reset.
- value  input  WIDTH  binary value to display (accumulator sum).
- hex  output  7*DIGITS  active-low segment patterns; hex[6:0] is the ones digit (HEX0), hex[13:7] is HEX1, and so on. Bit 0 = segment a … bit 6 = segment g.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when the display registers load.

Behaviour:
- Reset (async, RESETn=0):
  - FSM enters IDLE.
  - hex = all 7'h7F (blank); busy=0; done=0.
  - last_value=0; internal flag `first`=1, which forces a conversion on the first IDLE edge after reset release.
- States: IDLE, SHIFT, LOAD.
- IDLE (busy=0):
  - At a rising edge where value != last_value or first=1: capture value into shift register sreg and into last_value; clear the BCD register; set bit counter cnt=WIDTH; clear first; go to SHIFT.
  - Otherwise remain in IDLE.
- SHIFT (busy=1), each edge:
  - Every BCD digit >= 5 gets +3 (combinational correction).
  - The {bcd, sreg} concatenation shifts left by 1.
  - cnt decrements. When cnt reaches 1 at the edge, the shift still occurs and the FSM goes to LOAD.
  - Exactly WIDTH shift edges per conversion.
- LOAD (busy=1): each hex digit register is loaded with the segment encoding of its BCD digit; done=1 for the following cycle; go to IDLE.
- Latency: detection edge N; shifts on edges N+1..N+WIDTH; hex and done update on edge N+WIDTH+1. Default: 11 edges after detection.
- Segment encoding for digits 0-9: 40,79,24,30,19,12,02,78,00,10 (hex). A BCD digit > 9 cannot occur; if forced, the encoding is 7'h7F.
- Input changes while busy are ignored, not queued. The comparison in the next IDLE cycle picks up the newest value. The displayed value therefore always converges to the most recent stable input.
- A stable value never retriggers a conversion (no free-running refresh).
- Reset asserted mid-conversion aborts immediately:
  - Displays blank.
  - The partial BCD result is discarded.
  - A fresh conversion of the current value starts on the first edge after release.
- busy is a registered output: 1 in SHIFT and LOAD, 0 in IDLE.
- done never coincides with busy=1 in the same cycle.

Optional Feature:
- Macro: ACCUM_BCD_LEADING_ZERO_BLANK_EN.
- Defined: in LOAD, every digit above the most significant nonzero digit is driven 7'h7F (blank). The ones digit is never blanked, so value 0 shows only "0" on HEX0, and 42 shows blank,blank,4,2.
- Undefined: all DIGITS displays always show their digit, including leading zeros (42 shows 0,0,4,2).
- Reset, latency and handshake behaviour are identical in both builds.

Test Plan:
- Reset held 3 cycles, value=0, release: hex=7F7F7F7F (all blank) during reset. busy rises on the first edge after release. done pulses 11 edges later. hex = 40,40,40,40 (HEX3..HEX0), or 7F,7F,7F,40 with the blank macro.
- value=1023 from IDLE: busy=1 for exactly 11 cycles. hex digits HEX3..HEX0 = 79,40,24,30 ("1023"). done is a single-cycle pulse.
- value=999 (exercises add-3 on every digit): HEX3..HEX0 = 40,10,10,10 ("0999"), or HEX3 blank with the macro.
- value changes 5→37 on the third SHIFT cycle of the 5 conversion: the first conversion completes showing "0005". A second conversion starts on the next edge and ends showing "0037". busy drops for exactly one cycle between the two.
- RESETn pulsed low mid-SHIFT while converting 512: hex goes 7F immediately (asynchronously, no clock edge needed). After release, a complete conversion shows "0512", with no stale partial digits.
- value held constant at 300 for 100 cycles after display: exactly one done pulse; busy stays 0 afterwards; hex stable at "0300".

Source files
------------

// File: rtl/accum_bcd_display.sv
// accum_bcd_display: converts the accumulator's binary sum to decimal with a
// bit-serial shift-and-add-3 (double-dabble) FSM. It drives active-low
// seven-segment patterns, one HEX display per decimal digit.
// The display registers load atomically when a conversion completes.
// Optional build macro ACCUM_BCD_LEADING_ZERO_BLANK_EN: blanks every digit
// above the most significant nonzero digit. The ones digit is never blanked.
module accum_bcd_display #(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 4
) (
  input  logic                  CLOCK,
  input  logic                  RESETn,
  input  logic [WIDTH-1:0]      value,
  output logic [7*DIGITS-1:0]   hex,
  output logic                  busy,
  output logic                  done
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  // The decimal field must hold the largest binary input.
  if ((64'd10 ** DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_params
    $error("accum_bcd_display: DIGITS=%0d too small for WIDTH=%0d", DIGITS, WIDTH);
  end

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t              state_reg;
  logic [WIDTH-1:0]    sreg_reg;
  logic [WIDTH-1:0]    last_value_reg;
  logic [BW-1:0]       bcd_reg;
  logic [BW-1:0]       bcd_adj;
  logic [CW-1:0]       cnt_reg;
  logic                first_reg;
  logic [7*DIGITS-1:0] hex_reg;
  logic [7*DIGITS-1:0] seg_next;
  logic                busy_reg;
  logic                done_reg;

  // Active-low segment pattern; codes above 9 cannot arise and show blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // Add-3 correction per BCD digit ahead of each shift.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                  bcd_reg[4*gi +: 4] + 4'd3 :
                                  bcd_reg[4*gi +: 4];
    end
  endgenerate

  // Segment patterns for the finished BCD result, loaded in LOAD.
  always_comb begin : seg_sel
`ifdef ACCUM_BCD_LEADING_ZERO_BLANK_EN
    logic nz;
    nz       = 1'b0;
    seg_next = '1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nz = nz | (bcd_reg[4*i +: 4] != 4'd0);
      seg_next[7*i +: 7] = (nz || i == 0) ? seg7(bcd_reg[4*i +: 4]) : 7'h7F;
    end
`else
    seg_next = '1;
    for (int i = 0; i < DIGITS; i++) begin
      seg_next[7*i +: 7] = seg7(bcd_reg[4*i +: 4]);
    end
`endif
  end

  // Conversion FSM: detect a new value, shift WIDTH bits, then load displays.
  always_ff @(posedge CLOCK or negedge RESETn) begin
    if (!RESETn) begin
      state_reg      <= IDLE;
      sreg_reg       <= '0;
      last_value_reg <= '0;
      bcd_reg        <= '0;
      cnt_reg        <= '0;
      first_reg      <= 1'b1;
      hex_reg        <= {DIGITS{7'h7F}};
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if ((value != last_value_reg) || first_reg) begin
            sreg_reg       <= value;
            last_value_reg <= value;
            bcd_reg        <= '0;
            cnt_reg        <= CW'(WIDTH);
            first_reg      <= 1'b0;
            busy_reg       <= 1'b1;
            state_reg      <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_reg  <= {bcd_adj[BW-2:0], sreg_reg[WIDTH-1]};
          sreg_reg <= {sreg_reg[WIDTH-2:0], 1'b0};
          cnt_reg  <= cnt_reg - CW'(1);
          if (cnt_reg == CW'(1)) begin
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          hex_reg   <= seg_next;
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign hex  = hex_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_accum_bcd_display.sv
// Self-checking bench for accum_bcd_display: table-driven conversions plus
// hand-written sequences for reset, mid-conversion changes and stability.
module tb_accum_bcd_display;

  logic        CLOCK;
  logic        RESETn;
  logic [9:0]  value;
  logic [27:0] hex;
  logic        busy;
  logic        done;

  int total = 0;
  int bad = 0;
  int done_seen = 0;
  logic [27:0] exp_q[$];

  typedef struct {
    logic [9:0]  v;
    logic [27:0] h;
  } vec_t;
  vec_t tbl[7];

  accum_bcd_display #(.WIDTH(10), .DIGITS(4)) dut (
    .CLOCK(CLOCK),
    .RESETn(RESETn),
    .value(value),
    .hex(hex),
    .busy(busy),
    .done(done)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // Expected display: digit codes with leading zeros, blanked in the macro build.
  function automatic logic [27:0] disp(input logic [27:0] h);
    logic [27:0] r;
    r = h;
`ifdef ACCUM_BCD_LEADING_ZERO_BLANK_EN
    for (int i = 3; i > 0; i--) begin
      if (r[7*i +: 7] == 7'h40) r[7*i +: 7] = 7'h7F;
      else break;
    end
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // One sample point per cycle; a done pulse pops the scoreboard.
  task automatic tick();
    logic [27:0] e;
    @(negedge CLOCK);
    if (done === 1'b1) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'(hex), 64'h0);
      end else begin
        e = exp_q.pop_front();
        chk("hex_on_done", 64'(hex), 64'(e));
      end
    end
  endtask

  task automatic wait_conv(input string tag);
    int rise;
    int blen;
    rise = 0;
    blen = 0;
    while (busy !== 1'b1 && rise < 20) begin tick(); rise++; end
    while (busy === 1'b1 && blen < 40) begin tick(); blen++; end
    chk({tag, "_rise"}, 64'(rise), 64'd1);
    chk({tag, "_busy_len"}, 64'(blen), 64'd11);
    chk({tag, "_done"}, 64'(done), 64'd1);
    tick();
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int d0;
    int low_gap;
    bit prev_busy;
    bit fell;
    bit rose_again;
    bit busy_any;

    tbl[0] = '{10'd1023, {7'h79, 7'h40, 7'h24, 7'h30}};
    tbl[1] = '{10'd999,  {7'h40, 7'h10, 7'h10, 7'h10}};
    tbl[2] = '{10'd42,   {7'h40, 7'h40, 7'h19, 7'h24}};
    tbl[3] = '{10'd680,  {7'h40, 7'h02, 7'h00, 7'h40}};
    tbl[4] = '{10'd1,    {7'h40, 7'h40, 7'h40, 7'h79}};
    tbl[5] = '{10'd57,   {7'h40, 7'h40, 7'h12, 7'h78}};
    tbl[6] = '{10'd100,  {7'h40, 7'h79, 7'h40, 7'h40}};

    // Reset held three cycles with value 0.
    RESETn = 1'b0;
    value  = 10'd0;
    repeat (3) tick();
    chk("reset_hex", 64'(hex), 64'(28'hFFFFFFF));
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    exp_q.push_back(disp({4{7'h40}}));
    RESETn = 1'b1;
    wait_conv("first_zero");

    // Table-driven conversions from IDLE.
    for (int k = 0; k < 7; k++) begin
      value = tbl[k].v;
      exp_q.push_back(disp(tbl[k].h));
      wait_conv($sformatf("vec%0d_%0d", k, tbl[k].v));
      tick();
      chk($sformatf("vec%0d_idle", k), 64'(busy), 64'd0);
      $display("vector %0d: value=%0d hex=%07h", k, tbl[k].v, hex);
    end

    // Change 5 -> 37 during the third SHIFT cycle of the 5 conversion.
    d0 = done_seen;
    value = 10'd5;
    exp_q.push_back(disp({7'h40, 7'h40, 7'h40, 7'h12}));
    exp_q.push_back(disp({7'h40, 7'h40, 7'h30, 7'h78}));
    tick();
    tick();
    tick();
    value = 10'd37;
    low_gap = 0;
    prev_busy = busy;
    fell = 1'b0;
    rose_again = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (!busy && prev_busy) fell = 1'b1;
      if (fell && !rose_again) begin
        if (!busy) low_gap++;
        else rose_again = 1'b1;
      end
      prev_busy = busy;
    end
    chk("chg_two_dones", 64'(done_seen - d0), 64'd2);
    chk("chg_restart", 64'(rose_again), 64'd1);
    chk("chg_gap", 64'(low_gap), 64'd1);
    $display("change 5->37: dones=%0d gap=%0d hex=%07h", done_seen - d0, low_gap, hex);

    // Asynchronous reset mid-SHIFT while converting 512.
    value = 10'd512;
    exp_q.push_back(disp({7'h40, 7'h12, 7'h79, 7'h24}));
    tick();
    tick();
    tick();
    chk("abort_busy_before", 64'(busy), 64'd1);
    #2 RESETn = 1'b0;
    #1;
    chk("abort_hex_async", 64'(hex), 64'(28'hFFFFFFF));
    chk("abort_busy_async", 64'(busy), 64'd0);
    tick();
    RESETn = 1'b1;
    wait_conv("abort_512");
    $display("abort 512: hex=%07h", hex);

    // Hold 300 stable for 100 cycles after the display updates.
    d0 = done_seen;
    value = 10'd300;
    exp_q.push_back(disp({7'h40, 7'h30, 7'h40, 7'h40}));
    wait_conv("hold_300");
    busy_any = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (busy) busy_any = 1'b1;
    end
    chk("hold_one_done", 64'(done_seen - d0), 64'd1);
    chk("hold_no_busy", 64'(busy_any), 64'd0);
    chk("hold_hex", 64'(hex), 64'(disp({7'h40, 7'h30, 7'h40, 7'h40})));
    $display("hold 300: dones=%0d hex=%07h", done_seen - d0, hex);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
